// File: rtl/filter_peak_sequencer.sv
// rtl/filter_peak_sequencer.sv - filter flush/arm/peak-search/dead-time sequencer
// Finds the peak of each over-threshold pulse and hands it out through a one-deep event buffer.
module filter_peak_sequencer #(
  parameter int DATA_W     = 16,
  parameter int TS_W       = 32,
  parameter int FLUSH_LEN  = 32,
  parameter int SEARCH_LEN = 8,
  parameter int DEAD_LEN   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] filter_data,
  input  logic [DATA_W-1:0] threshold,
  output logic              filter_rst_n,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_amp,
  output logic [TS_W-1:0]   evt_time,
  output logic [15:0]       lost_cnt,
  output logic              busy
);

  localparam int MAX_LEN = (FLUSH_LEN > SEARCH_LEN) ?
                           ((FLUSH_LEN > DEAD_LEN) ? FLUSH_LEN : DEAD_LEN) :
                           ((SEARCH_LEN > DEAD_LEN) ? SEARCH_LEN : DEAD_LEN);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {DISABLED, FLUSH, ARMED, SEARCH, DEAD} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [TS_W-1:0]   ts;
  logic [DATA_W-1:0] peak, cand;
  logic [TS_W-1:0]   peak_ts, cand_ts;
  logic              above, newer, trigger, search_end;

  assign above   = filter_data > threshold;
  // Strict compare: on a tie the earlier sample keeps the peak.
  assign newer   = filter_data > peak;
  assign cand    = newer ? filter_data : peak;
  assign cand_ts = newer ? ts : peak_ts;

  assign filter_rst_n = (state != DISABLED);
  assign busy         = (state == FLUSH) || (state == SEARCH) || (state == DEAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DISABLED;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    trigger    = 1'b0;
    search_end = 1'b0;
    if (!enable) begin
      state_next = DISABLED;
      cnt_next   = '0;
    end else begin
      case (state)
        DISABLED: begin
          state_next = FLUSH;
          cnt_next   = '0;
        end
        FLUSH: begin
          if (cnt == CNT_W'(FLUSH_LEN - 1)) begin
            state_next = ARMED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        ARMED: begin
          if (above) begin
            trigger    = 1'b1;
            state_next = SEARCH;
            cnt_next   = '0;
          end
        end
        SEARCH: begin
          if (cnt == CNT_W'(SEARCH_LEN - 1)) begin
            search_end = 1'b1;
            state_next = DEAD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        DEAD: begin
          // Counter parks at the minimum; leaving also needs the input back at or below threshold.
          if (cnt == CNT_W'(DEAD_LEN - 1)) begin
            if (!above) begin
              state_next = ARMED;
              cnt_next   = '0;
            end
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = DISABLED;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts        <= '0;
      peak      <= '0;
      peak_ts   <= '0;
      evt_valid <= 1'b0;
      evt_amp   <= '0;
      evt_time  <= '0;
      lost_cnt  <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (trigger) begin
        peak    <= filter_data;
        peak_ts <= ts;
      end else if (state == SEARCH) begin
        peak    <= cand;
        peak_ts <= cand_ts;
      end

      if (!enable) begin
        evt_valid <= 1'b0;
      end else if (search_end && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        evt_amp   <= cand;
        evt_time  <= cand_ts;
      end else begin
        if (search_end && (lost_cnt != 16'hFFFF))
          lost_cnt <= lost_cnt + 16'd1;
        if (evt_ready)
          evt_valid <= 1'b0;
      end
    end
  end

endmodule
